// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU select encodings, flag indices and writeback classification helpers
package alu_pkg;

   localparam logic [4:0] SEL_MOV  = 5'b00000;
   localparam logic [4:0] SEL_ADD  = 5'b00001;
   localparam logic [4:0] SEL_ADDC = 5'b00010;
   localparam logic [4:0] SEL_SUB  = 5'b00011;
   localparam logic [4:0] SEL_SUBC = 5'b00100;
   localparam logic [4:0] SEL_CMP  = 5'b00101;
   localparam logic [4:0] SEL_DADD = 5'b00110;
   localparam logic [4:0] SEL_BIT  = 5'b00111;
   localparam logic [4:0] SEL_BIC  = 5'b01000;
   localparam logic [4:0] SEL_BIS  = 5'b01001;
   localparam logic [4:0] SEL_XOR  = 5'b01010;
   localparam logic [4:0] SEL_AND  = 5'b01011;
   localparam logic [4:0] SEL_CLR  = 5'b01100;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int CG_REG = 3;

   function automatic logic writes_result(input logic [4:0] sel);
      case (sel)
         SEL_MOV, SEL_ADD, SEL_ADDC, SEL_SUB, SEL_SUBC, SEL_DADD,
         SEL_BIC, SEL_BIS, SEL_XOR, SEL_AND, SEL_CLR: writes_result = 1'b1;
         default:                                     writes_result = 1'b0;
      endcase
   endfunction

   function automatic logic updates_flags(input logic [4:0] sel);
      case (sel)
         SEL_ADD, SEL_ADDC, SEL_SUB, SEL_SUBC, SEL_CMP,
         SEL_DADD, SEL_BIT, SEL_XOR, SEL_AND: updates_flags = 1'b1;
         default:                             updates_flags = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file, two combinational reads, one write, constant register reads zero
module alu_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we && waddr != AW'(CG_REG)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == AW'(CG_REG)) ? '0 : regs_q[raddr_a];
   assign rdata_b = (raddr_b == AW'(CG_REG)) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - one-entry commit register, status flags, operand and carry forwarding
module alu_writeback
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_sel,
   input  logic [DATA_W-1:0] in_result,
   input  logic [3:0]        in_flags,
   input  logic [AW-1:0]     in_dst,
   input  logic              in_byte,
   input  logic              rf_stall,
   input  logic [AW-1:0]     rd_addr_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [3:0]        sr_flags,
   output logic              carry_fwd,
   output logic              wb_done,
   output logic              illegal_op
);

   logic              pend_valid_q;
   logic [4:0]        sel_q;
   logic [DATA_W-1:0] result_q;
   logic [AW-1:0]     dst_q;
   logic              byte_q, c_q, v_q;
   logic [3:0]        sr_q;
   logic              wb_done_q, illegal_q;

   logic              accept, commit, logic_op, pend_fwd;
   logic              pend_n, pend_z, pend_c, pend_v;
   logic [DATA_W-1:0] pend_wdata, rf_a, rf_b;
   logic              unused_flags;

   assign unused_flags = ^in_flags[3:2];
   assign in_ready = !pend_valid_q || !rf_stall;
   assign accept   = in_valid && in_ready;
   assign commit   = pend_valid_q && !rf_stall;

   always_comb begin
      pend_wdata = byte_q ? {{(DATA_W-8){1'b0}}, result_q[7:0]} : result_q;
      pend_n     = byte_q ? result_q[7] : result_q[DATA_W-1];
      pend_z     = byte_q ? (result_q[7:0] == 8'h00) : (result_q == '0);
      logic_op   = (sel_q == SEL_BIT) || (sel_q == SEL_AND);
      pend_c     = logic_op ? !pend_z : c_q;
      pend_v     = logic_op ? 1'b0 : v_q;
      // the constant register is never forwarded so it keeps reading zero
      pend_fwd   = pend_valid_q && writes_result(sel_q) && (dst_q != AW'(CG_REG));
   end

   assign rd_data_a = (pend_fwd && dst_q == rd_addr_a) ? pend_wdata : rf_a;
   assign rd_data_b = (pend_fwd && dst_q == rd_addr_b) ? pend_wdata : rf_b;
   assign carry_fwd = (pend_valid_q && updates_flags(sel_q)) ? pend_c : sr_q[FLAG_C];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q <= 1'b0;
         sel_q        <= '0;
         result_q     <= '0;
         dst_q        <= '0;
         byte_q       <= 1'b0;
         c_q          <= 1'b0;
         v_q          <= 1'b0;
         sr_q         <= '0;
         wb_done_q    <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         if (accept) begin
            pend_valid_q <= 1'b1;
            sel_q        <= in_sel;
            result_q     <= in_result;
            dst_q        <= in_dst;
            byte_q       <= in_byte;
            c_q          <= in_flags[FLAG_C];
            v_q          <= in_flags[FLAG_V];
         end else if (commit) begin
            pend_valid_q <= 1'b0;
         end
         wb_done_q <= commit;
         if (commit && updates_flags(sel_q)) sr_q <= {pend_n, pend_z, pend_c, pend_v};
         if (commit && sel_q > SEL_CLR) illegal_q <= 1'b1;
      end
   end

   assign sr_flags   = sr_q;
   assign wb_done    = wb_done_q;
   assign illegal_op = illegal_q;

   alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (commit && writes_result(sel_q)),
      .waddr   (dst_q),
      .wdata   (pend_wdata),
      .raddr_a (rd_addr_a),
      .raddr_b (rd_addr_b),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed vector bench for alu_writeback
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_sel = '0;
   logic [15:0] in_result = '0;
   logic [3:0]  in_flags = '0;
   logic [3:0]  in_dst = '0;
   logic        in_byte = 1'b0;
   logic        rf_stall = 1'b0;
   logic [3:0]  rd_addr_a = '0;
   logic [3:0]  rd_addr_b = '0;
   logic [15:0] rd_data_a, rd_data_b;
   logic [3:0]  sr_flags;
   logic        carry_fwd, wb_done, illegal_op;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_writeback dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_result(in_result), .in_flags(in_flags), .in_dst(in_dst),
      .in_byte(in_byte), .rf_stall(rf_stall), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .sr_flags(sr_flags),
      .carry_fwd(carry_fwd), .wb_done(wb_done), .illegal_op(illegal_op)
   );

   typedef struct {
      logic [4:0]  sel;
      logic [15:0] result;
      logic [3:0]  flags;
      logic [3:0]  dst;
      logic        byt;
      logic [15:0] exp_reg;
      logic [3:0]  exp_sr;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] sel, input logic [15:0] res, input logic [3:0] fl,
                        input logic [3:0] dst, input logic byt);
      in_valid  = 1'b1;
      in_sel    = sel;
      in_result = res;
      in_flags  = fl;
      in_dst    = dst;
      in_byte   = byt;
   endtask

   initial begin
      vecs[0]  = '{5'b00001, 16'h8000, 4'b0011, 4'd5,  1'b0, 16'h8000, 4'b1011}; // ADD
      vecs[1]  = '{5'b00001, 16'h1200, 4'b0000, 4'd4,  1'b1, 16'h0000, 4'b0100}; // ADD.B
      vecs[2]  = '{5'b00000, 16'h0000, 4'b0011, 4'd5,  1'b0, 16'h0000, 4'b0100}; // MOV
      vecs[3]  = '{5'b00000, 16'h1234, 4'b0000, 4'd7,  1'b0, 16'h1234, 4'b0100}; // MOV
      vecs[4]  = '{5'b00101, 16'h0000, 4'b0010, 4'd7,  1'b0, 16'h1234, 4'b0110}; // CMP
      vecs[5]  = '{5'b00111, 16'h0004, 4'b0001, 4'd7,  1'b0, 16'h1234, 4'b0010}; // BIT
      vecs[6]  = '{5'b01011, 16'h0000, 4'b0011, 4'd8,  1'b0, 16'h0000, 4'b0100}; // AND
      vecs[7]  = '{5'b00011, 16'hFFFF, 4'b0001, 4'd9,  1'b0, 16'hFFFF, 4'b1001}; // SUB
      vecs[8]  = '{5'b01010, 16'h0180, 4'b0010, 4'd10, 1'b1, 16'h0080, 4'b1010}; // XOR.B
      vecs[9]  = '{5'b01001, 16'h5555, 4'b0000, 4'd3,  1'b0, 16'h0000, 4'b1010}; // BIS to R3
      vecs[10] = '{5'b01100, 16'h0000, 4'b0000, 4'd9,  1'b0, 16'h0000, 4'b1010}; // CLR
      vecs[11] = '{5'b00110, 16'h0099, 4'b0000, 4'd11, 1'b0, 16'h0099, 4'b0000}; // DADD
      vecs[12] = '{5'b01000, 16'h00F0, 4'b0011, 4'd12, 1'b0, 16'h00F0, 4'b0000}; // BIC

      // reset state
      #1;
      check("reset in_ready", 16'(in_ready), 16'h1);
      check("reset sr_flags", 16'(sr_flags), 16'h0);
      check("reset wb_done", 16'(wb_done), 16'h0);
      check("reset illegal_op", 16'(illegal_op), 16'h0);
      for (int r = 0; r < 16; r++) begin
         rd_addr_a = 4'(r);
         rd_addr_b = 4'(15 - r);
         #1;
         check($sformatf("reset R%0d port a", r), rd_data_a, 16'h0);
         check($sformatf("reset R%0d port b", 15 - r), rd_data_b, 16'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // table vectors: one op each, forwarded value then committed value
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i].sel, vecs[i].result, vecs[i].flags, vecs[i].dst, vecs[i].byt);
         @(negedge clk);
         in_valid = 1'b0;
         rd_addr_a = vecs[i].dst;
         #1;
         check($sformatf("v%0d forwarded read", i), rd_data_a, vecs[i].exp_reg);
         check($sformatf("v%0d wb_done before commit", i), 16'(wb_done), 16'h0);
         @(negedge clk);
         check($sformatf("v%0d wb_done", i), 16'(wb_done), 16'h1);
         check($sformatf("v%0d sr_flags", i), 16'(sr_flags), 16'(vecs[i].exp_sr));
         check($sformatf("v%0d committed read", i), rd_data_a, vecs[i].exp_reg);
         check($sformatf("v%0d illegal_op", i), 16'(illegal_op), 16'h0);
         @(negedge clk);
         check($sformatf("v%0d wb_done single pulse", i), 16'(wb_done), 16'h0);
      end

      // ADD with carry, then ADDC back-to-back
      drive(5'b00001, 16'h0001, 4'b0010, 4'd1, 1'b0);
      @(negedge clk);
      drive(5'b00010, 16'h0003, 4'b0000, 4'd2, 1'b0);
      rd_addr_a = 4'd1;
      #1;
      check("b2b carry_fwd from ADD", 16'(carry_fwd), 16'h1);
      check("b2b forwarded R1", rd_data_a, 16'h0001);
      check("b2b in_ready", 16'(in_ready), 16'h1);
      @(negedge clk);
      in_valid = 1'b0;
      rd_addr_b = 4'd2;
      #1;
      check("b2b ADD wb_done", 16'(wb_done), 16'h1);
      check("b2b ADD sr_flags", 16'(sr_flags), 16'b0010);
      check("b2b carry_fwd from ADDC", 16'(carry_fwd), 16'h0);
      check("b2b forwarded R2", rd_data_b, 16'h0003);
      @(negedge clk);
      check("b2b ADDC wb_done", 16'(wb_done), 16'h1);
      check("b2b ADDC sr_flags", 16'(sr_flags), 16'b0000);
      check("b2b committed R2", rd_data_b, 16'h0003);

      // stall with an op pending
      @(negedge clk);
      rf_stall = 1'b1;
      drive(5'b00001, 16'h00AA, 4'b0001, 4'd13, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rd_addr_a = 4'd13;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("stall%0d in_ready", k), 16'(in_ready), 16'h0);
         check($sformatf("stall%0d wb_done", k), 16'(wb_done), 16'h0);
         check($sformatf("stall%0d sr_flags", k), 16'(sr_flags), 16'h0);
         check($sformatf("stall%0d forwarded R13", k), rd_data_a, 16'h00AA);
         @(negedge clk);
      end
      rf_stall = 1'b0;
      #1;
      check("stall release in_ready", 16'(in_ready), 16'h1);
      @(negedge clk);
      check("stall commit wb_done", 16'(wb_done), 16'h1);
      check("stall commit sr_flags", 16'(sr_flags), 16'b0001);
      check("stall commit R13", rd_data_a, 16'h00AA);

      // unknown select
      @(negedge clk);
      drive(5'b11111, 16'hBEEF, 4'b1111, 4'd14, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rd_addr_a = 4'd14;
      #1;
      check("illegal no forward", rd_data_a, 16'h0000);
      @(negedge clk);
      check("illegal wb_done", 16'(wb_done), 16'h1);
      check("illegal_op set", 16'(illegal_op), 16'h1);
      check("illegal no write", rd_data_a, 16'h0000);
      check("illegal sr_flags", 16'(sr_flags), 16'b0001);
      drive(5'b00000, 16'h0007, 4'b0000, 4'd14, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("illegal_op sticky", 16'(illegal_op), 16'h1);
      check("R14 after MOV", rd_data_a, 16'h0007);

      // reset while an op is held by stall
      rf_stall = 1'b1;
      drive(5'b00001, 16'h1111, 4'b0011, 4'd15, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rd_addr_a = 4'd15;
      rd_addr_b = 4'd7;
      #1;
      check("pre-reset forwarded R15", rd_data_a, 16'h1111);
      rst_n = 1'b0;
      #1;
      check("mid-stall reset in_ready", 16'(in_ready), 16'h1);
      check("mid-stall reset sr_flags", 16'(sr_flags), 16'h0);
      check("mid-stall reset illegal_op", 16'(illegal_op), 16'h0);
      check("mid-stall reset R15", rd_data_a, 16'h0000);
      check("mid-stall reset R7", rd_data_b, 16'h0000);
      check("mid-stall reset carry_fwd", 16'(carry_fwd), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rf_stall = 1'b0;
      @(negedge clk);
      check("post-reset wb_done", 16'(wb_done), 16'h0);
      @(negedge clk);
      check("post-reset wb_done late", 16'(wb_done), 16'h0);
      check("post-reset R15", rd_data_a, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
